// File: rtl/rvl_ctrl_mbox_seq_pkg.sv
// Shared mailbox layout, sequencer state encoding and sizing helper for the
// Reveal-controller mailbox sequencer.
package rvl_ctrl_mbox_pkg;

  localparam int MBOX_CMD    = 0;
  localparam int MBOX_WDATA  = 1;
  localparam int MBOX_RDATA  = 2;
  localparam int MBOX_STATUS = 3;

  localparam int CMD_GO_BIT     = 31;
  localparam int CMD_WR_BIT     = 30;
  localparam int ST_DONE_BIT    = 31;
  localparam int ST_TIMEOUT_BIT = 30;
  localparam int SEQ_W          = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD_CMD,
    CMD_WAIT,
    RD_WDATA,
    WDATA_WAIT,
    BUS,
    WR_RDATA,
    WR_STATUS,
    CLR_CMD
  } mbox_state_e;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rvl_ctrl_mbox_seq_if.sv
// RAM port-B and user-register-bus signals of the mailbox sequencer.
// master = sequencer side, slave = RAM/fabric side.
interface rvl_ctrl_mbox_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  ram_ce;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  busy;

  modport master (
    output ram_ce, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata,
    output busy
  );

  modport slave (
    input  ram_ce, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata,
    input  busy
  );
endinterface

// File: rtl/rvl_ctrl_mbox_seq_timer.sv
// Loadable down-counter with zero flag; load wins over decrement and the
// count holds at zero rather than wrapping.
module rvl_ctrl_mbox_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rvl_ctrl_mbox_seq.sv
// Mailbox sequencer owning RAM port B: polls the command word, runs one user
// bus access per command, writes result/status back and clears GO.
// Optional done_irq output enabled by defining RVL_CTRL_MBOX_SEQ_IRQ_EN.
module rvl_ctrl_mbox_seq
  import rvl_ctrl_mbox_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MBOX_BASE      = 0,
  parameter int POLL_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic usr_clk,
  input  logic usr_rst,
  rvl_ctrl_mbox_seq_if.master mb
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
  ,
  output logic done_irq
`endif
);

  localparam int POLL_W = cnt_width(POLL_CYCLES);
  localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);
  // Counters run down to zero inclusive, so loading N-1 yields N cycles.
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);

  mbox_state_e state, state_nxt;

  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  tmo_flag;
  logic [SEQ_W-1:0]      seq;

  logic                  cmd_go;
  logic                  cmd_go_wr;
  logic                  poll_load;
  logic                  poll_zero;
  logic                  tmo_load;
  logic                  tmo_zero;

  logic                  ram_ce;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  bus_req;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input int off);
    return ADDR_WIDTH'(MBOX_BASE + off);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] status_word(input logic to,
                                                        input logic [SEQ_W-1:0] s);
    logic [DATA_WIDTH-1:0] w;
    w                 = '0;
    w[ST_DONE_BIT]    = 1'b1;
    w[ST_TIMEOUT_BIT] = to;
    w[SEQ_W-1:0]      = s;
    return w;
  endfunction

  // Only WR and the address were latched, so every other bit reads back as 0.
  function automatic logic [DATA_WIDTH-1:0] cleared_cmd(input logic wr,
                                                        input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] w;
    w                  = '0;
    w[CMD_WR_BIT]      = wr;
    w[ADDR_WIDTH-1:0]  = a;
    return w;
  endfunction

  assign cmd_go    = mb.ram_rdata[CMD_GO_BIT];
  assign cmd_go_wr = mb.ram_rdata[CMD_WR_BIT];
  assign poll_load = ((state == CMD_WAIT) && !cmd_go) || (state == CLR_CMD);
  assign tmo_load  = (state == CMD_WAIT) || (state == WDATA_WAIT);

  rvl_ctrl_mbox_timer #(
    .CNT_W   (POLL_W),
    .RST_VAL (POLL_LOAD)
  ) u_poll_timer (
    .clk      (usr_clk),
    .rst      (usr_rst),
    .load     (poll_load),
    .load_val (POLL_LOAD),
    .dec      (state == IDLE),
    .zero     (poll_zero)
  );

  rvl_ctrl_mbox_timer #(
    .CNT_W   (TMO_W),
    .RST_VAL ('0)
  ) u_tmo_timer (
    .clk      (usr_clk),
    .rst      (usr_rst),
    .load     (tmo_load),
    .load_val (TMO_LOAD),
    .dec      (state == BUS),
    .zero     (tmo_zero)
  );

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // One RAM access per state; the RAM and bus strobes are pure state decodes.
  always_comb begin
    state_nxt = state;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    bus_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (poll_zero) state_nxt = RD_CMD;
      end
      RD_CMD: begin
        ram_ce    = 1'b1;
        ram_addr  = word_addr(MBOX_CMD);
        state_nxt = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (!cmd_go)        state_nxt = IDLE;
        else if (cmd_go_wr) state_nxt = RD_WDATA;
        else                state_nxt = BUS;
      end
      RD_WDATA: begin
        ram_ce    = 1'b1;
        ram_addr  = word_addr(MBOX_WDATA);
        state_nxt = WDATA_WAIT;
      end
      WDATA_WAIT: begin
        state_nxt = BUS;
      end
      BUS: begin
        bus_req = 1'b1;
        if (mb.bus_ack)    state_nxt = cmd_wr ? WR_STATUS : WR_RDATA;
        else if (tmo_zero) state_nxt = WR_STATUS;
      end
      WR_RDATA: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = word_addr(MBOX_RDATA);
        ram_wdata = rdata_q;
        state_nxt = WR_STATUS;
      end
      WR_STATUS: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = word_addr(MBOX_STATUS);
        ram_wdata = status_word(tmo_flag, seq);
        state_nxt = CLR_CMD;
      end
      CLR_CMD: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = word_addr(MBOX_CMD);
        ram_wdata = cleared_cmd(cmd_wr, cmd_addr);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command latches drive the bus outputs directly, so they clear on reset.
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      cmd_wr   <= 1'b0;
      cmd_addr <= '0;
      wdata_q  <= '0;
      tmo_flag <= 1'b0;
      seq      <= '0;
    end else begin
      if ((state == CMD_WAIT) && cmd_go) begin
        cmd_wr   <= cmd_go_wr;
        cmd_addr <= mb.ram_rdata[ADDR_WIDTH-1:0];
        tmo_flag <= 1'b0;
      end
      if (state == WDATA_WAIT) wdata_q <= mb.ram_rdata;
      if ((state == BUS) && !mb.bus_ack && tmo_zero) tmo_flag <= 1'b1;
      if (state == WR_STATUS) seq <= seq + 1'b1;
    end
  end

  always_ff @(posedge usr_clk) begin
    if ((state == BUS) && mb.bus_ack && !cmd_wr) rdata_q <= mb.bus_rdata;
  end

`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      done_irq <= 1'b0;
    end else begin
      done_irq <= (state == WR_STATUS);
    end
  end
`endif

  assign mb.ram_ce    = ram_ce;
  assign mb.ram_we    = ram_we;
  assign mb.ram_addr  = ram_addr;
  assign mb.ram_wdata = ram_wdata;
  assign mb.bus_req   = bus_req;
  assign mb.bus_we    = cmd_wr;
  assign mb.bus_addr  = cmd_addr;
  assign mb.bus_wdata = wdata_q;
  assign mb.busy      = (state != IDLE);

endmodule

// File: tb/tb_rvl_ctrl_mbox_seq.sv
// Self-checking bench for rvl_ctrl_mbox_seq: RAM and bus models plus a
// command-level reference model of mailbox results.
`timescale 1ns/1ps
module tb_rvl_ctrl_mbox_seq;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int BASE = 4;
  localparam int POLL = 6;
  localparam int TMO  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvl_ctrl_mbox_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
  logic done_irq;
`endif

  rvl_ctrl_mbox_seq #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MBOX_BASE      (BASE),
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .usr_clk (clk),
    .usr_rst (rst),
    .mb      (ifc)
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
    ,
    .done_irq (done_irq)
`endif
  );

  // Dual-port RAM model: port A from the bench, port B from the DUT.
  logic [31:0] mem [0:15];
  logic [31:0] rdata_q = '0;
  logic        pa_we = 1'b0;
  logic [3:0]  pa_addr = '0;
  logic [31:0] pa_wdata = '0;
  int unsigned ram_wr_cnt = 0;

  always @(posedge clk) begin
    if (pa_we) mem[pa_addr] <= pa_wdata;
    if (ifc.ram_ce) begin
      if (ifc.ram_we) begin
        mem[ifc.ram_addr[3:0]] <= ifc.ram_wdata;
        ram_wr_cnt <= ram_wr_cnt + 1;
      end else begin
        rdata_q <= mem[ifc.ram_addr[3:0]];
      end
    end
  end
  assign ifc.ram_rdata = rdata_q;

  int checks = 0;
  int errors = 0;
  logic [15:0] seq_m = '0;

  task automatic pa_write(input int a, input logic [31:0] d);
    @(negedge clk);
    pa_we = 1'b1; pa_addr = a[3:0]; pa_wdata = d;
    @(negedge clk);
    pa_we = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = !ifc.busy;
    end
  endtask

  // Issue one command via port A and check the bus access and mailbox results.
  // ack_dly < 0 means the bus never acknowledges.
  task automatic run_cmd(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_dly);
    logic [31:0] w2_before, exp_w0, exp_w2, exp_w3;
    int unsigned wr_before;
    int last_rd, held, exp_lat, got_c;
    bit got, idle, to;
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
    int irq_n;
`endif
    to = (ack_dly < 0);
    wait_idle(idle);
    checks++;
    if (!idle) begin errors++; $display("FAIL %s pre_idle: busy=%b required 0", tag, ifc.busy); end
    if (wr) pa_write(BASE + 1, wdata);
    w2_before = mem[BASE + 2];
    pa_write(BASE, {1'b1, wr, 14'b0, addr});
    wr_before = ram_wr_cnt;

    exp_w0  = {1'b0, wr, 14'b0, addr};
    exp_w2  = (!wr && !to) ? rdata : w2_before;
    exp_w3  = {1'b1, to, 14'b0, seq_m};
    exp_lat = wr ? 4 : 2;

    last_rd = -100; got = 1'b0; got_c = 0;
    for (int c = 0; c < 4 * POLL + 20 && !got; c++) begin
      if (ifc.ram_ce && !ifc.ram_we && ifc.ram_addr == AW'(BASE)) last_rd = c;
      if (ifc.bus_req) begin got = 1'b1; got_c = c; end
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s bus_req: never asserted, required 1", tag);
    end else begin
      checks++;
      if (got_c - last_rd != exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d cycles after RD_CMD, required %0d", tag, got_c - last_rd, exp_lat);
      end
      checks++;
      if (ifc.bus_we !== wr || ifc.bus_addr !== addr) begin
        errors++; $display("FAIL %s bus_cmd: we=%b addr=%h, required we=%b addr=%h", tag, ifc.bus_we, ifc.bus_addr, wr, addr);
      end
      if (wr) begin
        checks++;
        if (ifc.bus_wdata !== wdata) begin
          errors++; $display("FAIL %s bus_wdata: %h required %h", tag, ifc.bus_wdata, wdata);
        end
      end
      held = 1;
      if (to) begin
        for (int i = 0; i < 3 * TMO; i++) begin
          @(negedge clk);
          if (!ifc.bus_req) break;
          held++;
        end
        checks++;
        if (held != TMO) begin
          errors++; $display("FAIL %s timeout_len: bus_req held %0d cycles, required %0d", tag, held, TMO);
        end
      end else begin
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk);
          if (ifc.bus_req) held++;
        end
        checks++;
        if (held != ack_dly + 1) begin
          errors++; $display("FAIL %s req_hold: bus_req held %0d cycles, required %0d", tag, held, ack_dly + 1);
        end
        ifc.bus_ack = 1'b1; ifc.bus_rdata = rdata;
        @(negedge clk);
        ifc.bus_ack = 1'b0; ifc.bus_rdata = $urandom;
        checks++;
        if (ifc.bus_req !== 1'b0) begin
          errors++; $display("FAIL %s req_drop: bus_req=%b after ack, required 0", tag, ifc.bus_req);
        end
      end
    end

    idle = 1'b0;
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
    irq_n = 0;
`endif
    for (int i = 0; i < 40 && !idle; i++) begin
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
      if (done_irq === 1'b1) irq_n++;
`endif
      if (!ifc.busy) idle = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL %s done_idle: busy stuck high", tag); end
    checks++;
    if (mem[BASE] !== exp_w0) begin
      errors++; $display("FAIL %s W0: %h required %h", tag, mem[BASE], exp_w0);
    end
    checks++;
    if (mem[BASE + 2] !== exp_w2) begin
      errors++; $display("FAIL %s W2: %h required %h", tag, mem[BASE + 2], exp_w2);
    end
    checks++;
    if (mem[BASE + 3] !== exp_w3) begin
      errors++; $display("FAIL %s W3: %h required %h", tag, mem[BASE + 3], exp_w3);
    end
    checks++;
    if (ram_wr_cnt - wr_before != ((wr || to) ? 2 : 3)) begin
      errors++; $display("FAIL %s ram_writes: %0d required %0d", tag, ram_wr_cnt - wr_before, (wr || to) ? 2 : 3);
    end
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
    checks++;
    if (irq_n != 1) begin
      errors++; $display("FAIL %s done_irq: %0d pulse cycles, required 1", tag, irq_n);
    end
`endif
    seq_m = seq_m + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) pa_write(i, 32'h0);
    checks++;
    if ({ifc.ram_ce, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.bus_req, ifc.bus_we,
         ifc.bus_addr, ifc.bus_wdata, ifc.busy} !== '0) begin
      errors++;
      $display("FAIL reset outputs: ce=%b we=%b addr=%h wd=%h req=%b bwe=%b baddr=%h bwd=%h busy=%b, required all 0",
               ifc.ram_ce, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.bus_req, ifc.bus_we,
               ifc.bus_addr, ifc.bus_wdata, ifc.busy);
    end
`ifdef RVL_CTRL_MBOX_SEQ_IRQ_EN
    checks++;
    if (done_irq !== 1'b0) begin errors++; $display("FAIL reset done_irq: %b required 0", done_irq); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle_poll();
    int s0, s1, busy_lo;
    bit bad_req, bad_ce, idle;
    int unsigned wc;
    s0 = -1; s1 = -1; busy_lo = 0; bad_req = 1'b0; bad_ce = 1'b0; wc = ram_wr_cnt;
    for (int c = 0; c < 3 * (POLL + 2) + 4 && s1 < 0; c++) begin
      @(negedge clk);
      if (ifc.bus_req) bad_req = 1'b1;
      if (!ifc.busy && ifc.ram_ce) bad_ce = 1'b1;
      if (ifc.ram_ce && !ifc.ram_we && ifc.ram_addr == AW'(BASE)) begin
        if (s0 < 0) s0 = c; else s1 = c;
      end else if (s0 >= 0 && !ifc.busy) begin
        busy_lo++;
      end
    end
    checks++;
    if (s0 < 0 || s1 - s0 != POLL + 2) begin
      errors++; $display("FAIL poll_period: strobes at %0d and %0d, required spacing %0d", s0, s1, POLL + 2);
    end
    checks++;
    if (busy_lo != POLL) begin
      errors++; $display("FAIL poll_busy_low: %0d idle cycles, required %0d", busy_lo, POLL);
    end
    checks++;
    if (bad_req || bad_ce) begin
      errors++; $display("FAIL poll_quiet: bus_req seen=%b ram_ce while idle=%b, required 0/0", bad_req, bad_ce);
    end
    wait_idle(idle);
    ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    ifc.bus_ack = 1'b0;
    bad_req = 1'b0;
    for (int c = 0; c < 2 * (POLL + 2); c++) begin
      @(negedge clk);
      if (ifc.bus_req) bad_req = 1'b1;
    end
    checks++;
    if (bad_req || ram_wr_cnt != wc) begin
      errors++; $display("FAIL stray_ack: bus_req=%b ram_writes=%0d, required 0/0", bad_req, ram_wr_cnt - wc);
    end
  endtask

  task automatic test_write_cmd();
    run_cmd("write", 1'b1, 16'h0012, 32'hDEAD_BEEF, 32'h0, 3);
    checks++;
    if (mem[BASE + 3] !== 32'h8000_0000 || mem[BASE] !== 32'h4000_0012) begin
      errors++; $display("FAIL write_words: W3=%h W0=%h, required 80000000 40000012", mem[BASE + 3], mem[BASE]);
    end
  endtask

  task automatic test_read_cmd();
    run_cmd("read", 1'b0, 16'h0034, 32'h0, 32'h1234_5678, 1);
    checks++;
    if (mem[BASE + 2] !== 32'h1234_5678 || mem[BASE + 3] !== 32'h8000_0001 || mem[BASE] !== 32'h0000_0034) begin
      errors++; $display("FAIL read_words: W2=%h W3=%h W0=%h, required 12345678 80000001 00000034",
                         mem[BASE + 2], mem[BASE + 3], mem[BASE]);
    end
  endtask

  task automatic test_timeout();
    run_cmd("timeout", 1'b0, 16'h0056, 32'h0, 32'hFFFF_FFFF, -1);
    checks++;
    if (mem[BASE + 3] !== 32'hC000_0002 || mem[BASE + 2] !== 32'h1234_5678) begin
      errors++; $display("FAIL timeout_words: W3=%h W2=%h, required c0000002 12345678", mem[BASE + 3], mem[BASE + 2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      bit wr;
      int dly;
      wr  = 1'($urandom_range(0, 1));
      dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8));
      run_cmd($sformatf("rand%0d", i), wr, 16'($urandom), $urandom, $urandom, dly);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit got, idle;
    int unsigned wc;
    logic [31:0] w3b;
    wait_idle(idle);
    pa_write(BASE, 32'h8000_0055);
    got = 1'b0;
    for (int i = 0; i < 4 * POLL + 20 && !got; i++) begin
      @(negedge clk);
      got = ifc.bus_req;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_mid bus_req: never asserted, required 1"); end
    wc = ram_wr_cnt; w3b = mem[BASE + 3];
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.ram_ce, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.bus_req, ifc.bus_we,
         ifc.bus_addr, ifc.bus_wdata, ifc.busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs: req=%b bwe=%b baddr=%h bwd=%h busy=%b ce=%b, required all 0",
               ifc.bus_req, ifc.bus_we, ifc.bus_addr, ifc.bus_wdata, ifc.busy, ifc.ram_ce);
    end
    pa_write(BASE, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * (POLL + 2)) @(negedge clk);
    checks++;
    if (ram_wr_cnt != wc || mem[BASE + 3] !== w3b) begin
      errors++; $display("FAIL rst_mid no_writeback: writes=%0d W3=%h, required 0 and %h", ram_wr_cnt - wc, mem[BASE + 3], w3b);
    end
    seq_m = '0;
    run_cmd("post_rst", 1'b0, 16'h0077, 32'h0, 32'hA5A5_0F0F, 2);
  endtask

  initial begin
    ifc.bus_ack   = 1'b0;
    ifc.bus_rdata = '0;
    test_reset();
    test_idle_poll();
    test_write_cmd();
    test_read_cmd();
    test_timeout();
    test_random();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
